div_iter_unit: RTL and testbench

- Parametrised multi-cycle radix-2 restoring divider for the EX stage.
- Generalises the existing fixed 32-bit divider with configurable WIDTH and explicit busy/stall and divide-by-zero reporting.
- It also has a defined annul path and an optional early-out mode.
- Result feeds the HI/LO register as {remainder, quotient}; the hazard unit stalls EX on `busy`.

---
 rtl/div_iter_unit.sv | 154 +++++++++++++++
 tb/tb_div_iter_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring divider producing {remainder, quotient} for the HI/LO register.
// Define DIV_EARLY_OUT_EN to skip leading-zero iterations of the dividend.
module div_iter_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               annul,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               busy,
    output logic               div_by_zero
);

    typedef enum logic [1:0] {IDLE, DIVZERO, ON, DONE} divStateT;

    divStateT stateReg, stateNext;

    logic [WIDTH-1:0]   dividendReg, divisorReg, remReg, quotReg;
    logic [CNT_W-1:0]   counter, iterTarget;
    logic               signA, signB, signedReg;
    logic [2*WIDTH-1:0] resultReg;
    logic               readyReg, busyReg, divByZeroReg;
    logic               readyNext, busyNext;

    logic [WIDTH-1:0]   absA, absB, startDividend;
    logic [CNT_W-1:0]   startTarget;
    logic               isZeroDivisor, lastIter, fits;
    logic [WIDTH:0]     partial;
    logic [WIDTH-1:0]   remNext, quotNext, fixQuot, fixRem;

    assign absA          = (signed_div && opdata1[WIDTH-1]) ? (~opdata1 + WIDTH'(1)) : opdata1;
    assign absB          = (signed_div && opdata2[WIDTH-1]) ? (~opdata2 + WIDTH'(1)) : opdata2;
    assign isZeroDivisor = (opdata2 == '0);

`ifdef DIV_EARLY_OUT_EN
    logic [CNT_W-1:0] leadZeros;

    // Highest set bit wins because the loop walks upward; an all-zero value keeps WIDTH.
    always_comb begin
        leadZeros = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (absA[i]) leadZeros = CNT_W'(WIDTH - 1 - i);
        end
    end

    assign startDividend = absA << leadZeros;
    assign startTarget   = (leadZeros == CNT_W'(WIDTH)) ? CNT_W'(1) : (CNT_W'(WIDTH) - leadZeros);
`else
    assign startDividend = absA;
    assign startTarget   = CNT_W'(WIDTH);
`endif

    // The partial remainder keeps an extra top bit so divisors with the MSB set still compare correctly.
    assign partial  = {remReg, dividendReg[WIDTH-1]};
    assign fits     = (partial >= {1'b0, divisorReg});
    assign remNext  = fits ? (partial[WIDTH-1:0] - divisorReg) : partial[WIDTH-1:0];
    assign quotNext = {quotReg[WIDTH-2:0], fits};
    assign lastIter = (counter == (iterTarget - CNT_W'(1)));

    // Most-negative / -1 falls out naturally: the negated magnitude wraps back to itself.
    assign fixQuot = (signedReg && (signA ^ signB)) ? (~quotNext + WIDTH'(1)) : quotNext;
    assign fixRem  = (signedReg && signA) ? (~remNext + WIDTH'(1)) : remNext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg <= IDLE;
            readyReg <= 1'b0;
            busyReg  <= 1'b0;
        end else begin
            stateReg <= stateNext;
            readyReg <= readyNext;
            busyReg  <= busyNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (start) stateNext = isZeroDivisor ? DIVZERO : ON;
            DIVZERO: stateNext = DONE;
            ON: begin
                if (annul)         stateNext = IDLE;
                else if (lastIter) stateNext = DONE;
            end
            DONE:    if (annul || !start) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Flags are decoded from the upcoming state and registered so outputs never see inputs directly.
    always_comb begin
        readyNext = (stateNext == DONE);
        busyNext  = (stateNext == ON) || (stateNext == DIVZERO);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dividendReg  <= '0;
            divisorReg   <= '0;
            remReg       <= '0;
            quotReg      <= '0;
            counter      <= '0;
            iterTarget   <= '0;
            signA        <= 1'b0;
            signB        <= 1'b0;
            signedReg    <= 1'b0;
            resultReg    <= '0;
            divByZeroReg <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (start) begin
                        divByZeroReg <= 1'b0;
                        signedReg    <= signed_div;
                        signA        <= signed_div & opdata1[WIDTH-1];
                        signB        <= signed_div & opdata2[WIDTH-1];
                        counter      <= '0;
                        remReg       <= '0;
                        quotReg      <= '0;
                        divisorReg   <= absB;
                        iterTarget   <= startTarget;
                        dividendReg  <= isZeroDivisor ? opdata1 : startDividend;
                    end
                end
                ON: begin
                    if (!annul) begin
                        remReg      <= remNext;
                        quotReg     <= quotNext;
                        dividendReg <= dividendReg << 1;
                        counter     <= counter + CNT_W'(1);
                        if (lastIter) resultReg <= {fixRem, fixQuot};
                    end
                end
                DIVZERO: begin
                    resultReg    <= {dividendReg, {WIDTH{1'b1}}};
                    divByZeroReg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign result      = resultReg;
    assign ready       = readyReg;
    assign busy        = busyReg;
    assign div_by_zero = divByZeroReg;

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: scoreboard of expected {remainder, quotient}, flags and latency.
// Latency expectations follow DIV_EARLY_OUT_EN when it is defined.
module tb_div_iter_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, annul, signedDiv;
    logic [31:0] opdata1, opdata2;
    logic [63:0] result;
    logic        ready, busy, divByZero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] result;
        logic        dbz;
        int          lat;
    } expT;

    expT         sb[$];
    logic [63:0] lastRes;

    div_iter_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .annul(annul), .signed_div(signedDiv),
        .opdata1(opdata1), .opdata2(opdata2), .result(result), .ready(ready),
        .busy(busy), .div_by_zero(divByZero)
    );

    always #5 clk = ~clk;

    // Reference model built from the language's own division operators.
    function automatic expT modelDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        expT         e;
        logic [31:0] q, r, mag;
        int          lz, iters;
        if (b == 32'd0) begin
            e.result = {a, 32'hFFFF_FFFF};
            e.dbz    = 1'b1;
            e.lat    = 2;
            return e;
        end
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        e.result = {r, q};
        e.dbz    = 1'b0;
        mag      = (sgn && a[31]) ? -a : a;
        lz       = 32;
        for (int i = 31; i >= 0; i--) begin
            if (mag[i]) begin
                lz = 31 - i;
                break;
            end
        end
`ifdef DIV_EARLY_OUT_EN
        iters = 32 - lz;
        if (iters < 1) iters = 1;
`else
        iters = 32;
`endif
        e.lat = iters + 1;
        return e;
    endfunction

    // Pushes the expectation, raises start and waits (bounded) for ready; start stays high.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                 input bit scramble, output logic [63:0] res, output logic dbz,
                                 output int lat, output int busyErrs);
        sb.push_back(modelDiv(a, b, sgn));
        opdata1   = a;
        opdata2   = b;
        signedDiv = sgn;
        start     = 1'b1;
        @(posedge clk); #1;
        lat      = 1;
        busyErrs = 0;
        while (ready !== 1'b1 && lat < 200) begin
            if (busy !== 1'b1) busyErrs++;
            if (scramble) begin
                opdata1   = $urandom;
                opdata2   = $urandom;
                signedDiv = ~signedDiv;
            end
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        dbz = divByZero;
    endtask

    task automatic dropStart();
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; annul = 1'b0; signedDiv = 1'b0;
        opdata1 = '0; opdata2 = '0;
        #2;
        checks++;
        if ({result, ready, busy, divByZero} !== 67'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got res=%h rdy=%b busy=%b dbz=%b expected all 0", result, ready, busy, divByZero);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({ready, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got rdy=%b busy=%b expected 0 0", ready, busy);
        end
        lastRes = '0;
    endtask

    task automatic test_unsigned();
        logic [31:0] aTab[6] = '{32'd100, 32'hFFFF_FFFF, 32'd12345678, 32'd3, 32'hDEAD_BEEF, 32'h8000_0000};
        logic [31:0] bTab[6] = '{32'd7, 32'h8000_0001, 32'd1, 32'd10, 32'd17, 32'hFFFF_FFFF};
        logic [63:0] res;
        logic        dbz;
        int          lat, busyErrs;
        expT         e;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(aTab[i], bTab[i], 1'b0, 1'b0, res, dbz, lat, busyErrs);
            e = sb.pop_front();
            checks += 4;
            if (lat !== e.lat)  begin errors++; $display("[TB] FAIL u_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
            if (res !== e.result) begin errors++; $display("[TB] FAIL u_result[%0d]: got %h expected %h", i, res, e.result); end
            if (dbz !== 1'b0)   begin errors++; $display("[TB] FAIL u_dbz[%0d]: got %b expected 0", i, dbz); end
            if (busyErrs != 0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL u_busy[%0d]: got %0d low-busy cycles, busy at ready=%b expected 0, 0", i, busyErrs, busy);
            end
            if (i == 0) begin
                @(posedge clk); #1;
                checks++;
                if (ready !== 1'b1 || result !== e.result) begin
                    errors++;
                    $display("[TB] FAIL u_hold: got rdy=%b res=%h expected 1 %h", ready, result, e.result);
                end
            end
            dropStart();
            checks++;
            if (ready !== 1'b0) begin errors++; $display("[TB] FAIL u_ready_drop[%0d]: got %b expected 0", i, ready); end
            lastRes = e.result;
        end
    endtask

    task automatic test_signed();
        logic [31:0] aTab[5] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7, 32'hFFFF_FFF8, 32'h8000_0000};
        logic [31:0] bTab[5] = '{32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd3};
        logic [63:0] res;
        logic        dbz;
        int          lat, busyErrs;
        expT         e;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(aTab[i], bTab[i], 1'b1, 1'b0, res, dbz, lat, busyErrs);
            e = sb.pop_front();
            checks += 3;
            if (res !== e.result) begin errors++; $display("[TB] FAIL s_result[%0d]: got %h expected %h", i, res, e.result); end
            if (lat !== e.lat)    begin errors++; $display("[TB] FAIL s_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
            if (dbz !== 1'b0)     begin errors++; $display("[TB] FAIL s_dbz[%0d]: got %b expected 0", i, dbz); end
            dropStart();
            lastRes = e.result;
        end
    endtask

    task automatic test_divzero();
        logic [31:0] aTab[3] = '{32'd5, 32'hFFFF_FFF9, 32'd9};
        logic [31:0] bTab[3] = '{32'd0, 32'd0, 32'd3};
        logic        sTab[3] = '{1'b0, 1'b1, 1'b0};
        logic [63:0] res;
        logic        dbz;
        int          lat, busyErrs;
        expT         e;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(aTab[i], bTab[i], sTab[i], 1'b0, res, dbz, lat, busyErrs);
            e = sb.pop_front();
            checks += 4;
            if (lat !== e.lat)    begin errors++; $display("[TB] FAIL dz_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
            if (res !== e.result) begin errors++; $display("[TB] FAIL dz_result[%0d]: got %h expected %h", i, res, e.result); end
            if (dbz !== e.dbz)    begin errors++; $display("[TB] FAIL dz_flag[%0d]: got %b expected %b", i, dbz, e.dbz); end
            if (busyErrs != 0)    begin errors++; $display("[TB] FAIL dz_busy[%0d]: got %0d low-busy cycles expected 0", i, busyErrs); end
            dropStart();
            lastRes = e.result;
        end
    endtask

    task automatic test_annul();
        logic [63:0] res;
        logic        dbz;
        int          lat, busyErrs, readyRose;
        expT         e;
        opdata1 = 32'd1000; opdata2 = 32'd3; signedDiv = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        readyRose = 0;
        for (int c = 1; c < 10; c++) begin
            if (ready === 1'b1) readyRose++;
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL annul_inflight: got busy=%b expected 1", busy); end
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0;
        checks += 3;
        if (readyRose != 0 || ready !== 1'b0) begin errors++; $display("[TB] FAIL annul_ready: got %0d/%b expected 0/0", readyRose, ready); end
        if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL annul_idle: got busy=%b expected 0", busy); end
        if (result !== lastRes) begin errors++; $display("[TB] FAIL annul_result: got %h expected %h", result, lastRes); end
        applyStimulus(32'd8, 32'd2, 1'b0, 1'b0, res, dbz, lat, busyErrs);
        e = sb.pop_front();
        checks += 2;
        if (lat !== e.lat)    begin errors++; $display("[TB] FAIL annul_next_latency: got %0d expected %0d", lat, e.lat); end
        if (res !== e.result) begin errors++; $display("[TB] FAIL annul_next_result: got %h expected %h", res, e.result); end
        // annul while DONE with start still high must leave DONE
        annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0;
        start = 1'b0;
        checks += 2;
        if (ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL annul_done: got rdy=%b busy=%b expected 0 0", ready, busy); end
        if (result !== e.result) begin errors++; $display("[TB] FAIL annul_done_hold: got %h expected %h", result, e.result); end
        @(posedge clk); #1;
        lastRes = e.result;
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        logic        dbz;
        int          lat, busyErrs;
        expT         e;
        opdata1 = 32'd1000; opdata2 = 32'd3; signedDiv = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        repeat (14) begin @(posedge clk); #1; end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_inflight: got busy=%b expected 1", busy); end
        rst = 1'b0;
        start = 1'b0;
        #1;
        checks++;
        if ({result, ready, busy, divByZero} !== 67'd0) begin
            errors++;
            $display("[TB] FAIL rst_async: got res=%h rdy=%b busy=%b dbz=%b expected all 0", result, ready, busy, divByZero);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        applyStimulus(32'd7, 32'd7, 1'b0, 1'b0, res, dbz, lat, busyErrs);
        e = sb.pop_front();
        checks += 2;
        if (res !== e.result) begin errors++; $display("[TB] FAIL rst_next_result: got %h expected %h", res, e.result); end
        if (lat !== e.lat)    begin errors++; $display("[TB] FAIL rst_next_latency: got %0d expected %0d", lat, e.lat); end
        dropStart();
        lastRes = e.result;
    endtask

    task automatic test_early_out();
        logic [31:0] aTab[4] = '{32'd100, 32'd0, 32'd1, 32'hFFFF_FF9C};
        logic [31:0] bTab[4] = '{32'd7, 32'd5, 32'd1, 32'd7};
        logic        sTab[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [63:0] res;
        logic        dbz;
        int          lat, busyErrs;
        expT         e;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(aTab[i], bTab[i], sTab[i], 1'b0, res, dbz, lat, busyErrs);
            e = sb.pop_front();
            checks += 2;
            if (lat !== e.lat)    begin errors++; $display("[TB] FAIL eo_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
            if (res !== e.result) begin errors++; $display("[TB] FAIL eo_result[%0d]: got %h expected %h", i, res, e.result); end
            dropStart();
            lastRes = e.result;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic        sgn;
        logic [63:0] res;
        logic        dbz;
        int          lat, busyErrs;
        expT         e;
        for (int i = 0; i < 5; i++) begin
            a   = $urandom;
            b   = (i == 0) ? 32'h0000_1234 : ($urandom >> $urandom_range(0, 30));
            sgn = 1'($urandom_range(0, 1));
            applyStimulus(a, b, sgn, 1'b1, res, dbz, lat, busyErrs);
            e = sb.pop_front();
            checks += 3;
            if (res !== e.result) begin errors++; $display("[TB] FAIL b2b_result[%0d]: got %h expected %h (a=%h b=%h s=%b)", i, res, e.result, a, b, sgn); end
            if (dbz !== e.dbz)    begin errors++; $display("[TB] FAIL b2b_dbz[%0d]: got %b expected %b", i, dbz, e.dbz); end
            if (lat !== e.lat)    begin errors++; $display("[TB] FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
            dropStart();
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_divzero();
        test_annul();
        test_reset_mid();
        test_early_out();
        test_back_to_back();
        checks++;
        if (sb.size() !== 0) begin errors++; $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
